// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the PISO transmit controller.
// Optional parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_tx_pkg;

  // Controller states; PARITY is only reachable when parity is enabled.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DIV   = 1;
  localparam int DEFAULT_GAP   = 1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load, shift-right register; q_o is the LSB.
// Zeros are shifted in at the MSB end.
module piso_shift_reg
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             q_o
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  // Per-bit next value: load wins over shift, otherwise hold.
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic upper;
    if (gi == WIDTH - 1) begin : g_top
      assign upper = 1'b0;
    end else begin : g_mid
      assign upper = sreg_q[gi+1];
    end
    assign sreg_d[gi] = load_i ? d_i[gi] : (shift_i ? upper : sreg_q[gi]);
  end

  // Register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign q_o = sreg_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Transmit controller for a PISO shift register: accepts a word on a
// valid/ready handshake, sends it LSB-first holding each bit DIV clocks,
// then idles GAP clocks. Define PISO_TX_PARITY_EN to append an even
// parity bit after the data bits.
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int DIV_W = cnt_width(DIV);
  localparam int GAP_W = cnt_width(GAP + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q;
  logic             frame_end;
  logic             sreg_load;
  logic             sreg_shift;
  logic             sreg_bit;
  logic             div_last;
  logic             bit_last;
  logic             gap_last;
  logic             abort_act;

`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign div_last  = (div_cnt_q == DIV_LAST);
  assign bit_last  = (bit_cnt_q == BIT_LAST);
  assign gap_last  = (gap_cnt_q == GAP_LAST);
  // Abort only matters while a frame is in flight.
  assign abort_act = abort && (state_q != ST_IDLE);

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sreg (
    .clk    (clk),
    .rst    (rst),
    .load_i (sreg_load),
    .shift_i(sreg_shift),
    .d_i    (in_data),
    .q_o    (sreg_bit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; frame_end marks the clock where a frame completes.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_last && bit_last) begin
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
          frame_end = 1'b1;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        if (div_last) begin
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
          frame_end = 1'b1;
        end
      end
`endif
      ST_GAP: begin
        if (gap_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d   = ST_IDLE;
      frame_end = 1'b0;
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SHIFT: begin
        ser_out   = sreg_bit;
        ser_valid = 1'b1;
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        ser_out   = parity_q;
        ser_valid = 1'b1;
      end
`endif
      default: begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
      end
    endcase
  end

  // Counter and shift-register control for the current state.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sreg_load  = 1'b0;
    sreg_shift = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sreg_load = 1'b1;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          gap_cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
          parity_d  = ^in_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (bit_last) begin
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            sreg_shift = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);
      end
`endif
      ST_GAP: begin
        gap_cnt_d = gap_last ? '0 : gap_cnt_q + GAP_W'(1);
      end
      default: ;
    endcase
    if (abort_act) begin
      bit_cnt_d  = '0;
      div_cnt_d  = '0;
      gap_cnt_d  = '0;
      sreg_shift = 1'b0;
    end
  end

  // Counter and done-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= frame_end;
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity of the loaded word, captured at the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign done = done_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl (WIDTH=4, DIV=2, GAP=1).
`timescale 1ns/1ps
module tb_piso_tx_ctrl;

  localparam int W   = 4;
  localparam int DIV = 2;
  localparam int GAP = 1;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         in_valid = 1'b0;
  logic         abort    = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         in_ready, ser_out, ser_valid, busy, done;

  piso_tx_ctrl #(.WIDTH(W), .DIV(DIV), .GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .abort    (abort),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic b;
  } bit_t;

  bit_t exp_bits[$];   // expected serial bit per cycle
  int   exp_done[$];   // cycles where done must pulse
  int   free_at   = 0; // first cycle the controller is idle again
  bit   in_reset  = 1'b1;
  int   checks    = 0;
  int   failures  = 0;
  int   n_frames  = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is WIDTH data bits LSB-first (plus parity),
  // each held DIV cycles, starting the cycle after the handshake.
  task automatic model_handshake(input int c, input logic [W-1:0] d);
    bit_t e;
    int   t;
    t = c + 1;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < DIV; j++) begin
        e.c = t;
        e.b = d[i];
        exp_bits.push_back(e);
        t++;
      end
    end
`ifdef PISO_TX_PARITY_EN
    for (int j = 0; j < DIV; j++) begin
      e.c = t;
      e.b = (($countones(d) % 2) == 1);
      exp_bits.push_back(e);
      t++;
    end
`endif
    exp_done.push_back(t);
    free_at = t + GAP;
    n_frames++;
    $display("TX frame %0d: word=%h accepted in cycle %0d", n_frames, d, c);
  endtask

  task automatic model_abort(input int c);
    while (exp_bits.size() > 0 && exp_bits[$].c > c) void'(exp_bits.pop_back());
    while (exp_done.size() > 0 && exp_done[$] > c) void'(exp_done.pop_back());
    free_at = c + 1;
    $display("TX abort in cycle %0d", c);
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge).
  task automatic step(input bit v, input logic [W-1:0] d, input bit ab);
    int c;
    in_valid = v;
    in_data  = d;
    abort    = ab;
    c        = cyc;
    @(posedge clk);
    if (ab && c < free_at) model_abort(c);
    else if (v && c >= free_at) model_handshake(c, d);
    #1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    in_valid = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    exp_bits.delete();
    exp_done.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    free_at  = cyc;
    in_reset = 1'b0;
    $display("TX reset released in cycle %0d", cyc);
  endtask

  // Monitor: compares every output against the scoreboard each cycle.
  always @(negedge clk) begin : monitor
    bit exp_rdy, exp_sv, exp_dn;
    int c;
    if (!in_reset) begin
      c       = cyc;
      exp_rdy = (c >= free_at);
      chk("in_ready", in_ready, exp_rdy);
      chk("busy", busy, !exp_rdy);
      exp_sv = (exp_bits.size() > 0) && (exp_bits[0].c == c);
      chk("ser_valid", ser_valid, exp_sv);
      if (exp_sv) begin
        chk("ser_out", ser_out, exp_bits[0].b);
        void'(exp_bits.pop_front());
      end else begin
        chk("ser_out_idle", ser_out, 1'b0);
      end
      exp_dn = (exp_done.size() > 0) && (exp_done[0] == c);
      chk("done", done, exp_dn);
      if (exp_dn) void'(exp_done.pop_front());
    end
  end

  initial begin : stim
    int f0;
    #1;
    do_reset();

    // Basic frame 1011.
    step(1'b1, 4'b1011, 1'b0);
    repeat (12) step(1'b0, W'($urandom), 1'b0);

    // Back-to-back with in_valid held high: A then 5.
    step(1'b1, 4'hA, 1'b0);
    f0 = n_frames;
    for (int k = 0; k < 15 && n_frames == f0; k++) step(1'b1, 4'h5, 1'b0);
    repeat (12) step(1'b0, W'($urandom), 1'b0);

    // Abort during the third bit period of F.
    step(1'b1, 4'hF, 1'b0);
    repeat (4) step(1'b0, W'($urandom), 1'b0);
    step(1'b0, W'($urandom), 1'b1);
    repeat (6) step(1'b0, W'($urandom), 1'b0);

    // Abort while idle still allows the handshake.
    step(1'b1, 4'h6, 1'b1);
    repeat (12) step(1'b0, W'($urandom), 1'b0);

    // Abort during the last bit cycle suppresses done.
    step(1'b1, 4'h3, 1'b0);
    repeat (7) step(1'b0, W'($urandom), 1'b0);
    step(1'b0, W'($urandom), 1'b1);
    repeat (4) step(1'b0, W'($urandom), 1'b0);

    // Reset mid-frame, then a fresh word.
    step(1'b1, 4'h9, 1'b0);
    repeat (3) step(1'b0, W'($urandom), 1'b0);
    do_reset();
    step(1'b1, 4'h3, 1'b0);
    repeat (12) step(1'b0, W'($urandom), 1'b0);

    // Input stability: data toggles every cycle while busy.
    step(1'b1, 4'hC, 1'b0);
    repeat (10) step(1'b0, W'($urandom), 1'b0);
    repeat (30) step(1'b1, W'($urandom), 1'b0);

    // Randomised traffic with occasional abort and reset.
    repeat (400) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'(($urandom_range(0, 1))), W'($urandom), ($urandom_range(0, 99) < 4));
    end

    // Drain and confirm every expected event was observed.
    repeat (15) step(1'b0, W'($urandom), 1'b0);
    chk("drain_bits", (exp_bits.size() == 0), 1'b1);
    chk("drain_done", (exp_done.size() == 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
